// File: rtl/dsp19x2_fir_sequencer_pkg.sv
// Shared types and constants for the DSP19X2 FIR sequencer.
//   seq_state_t : sequencer FSM states (IDLE, TAP)
//   NUM_TAPS, B_W, Z_W, FIFO_DEPTH, TAG_STAGES : datapath geometry
//   fb_sel(k)   : FEEDBACK code that selects stored coefficient k
package dsp19x2_seq_pkg;

    typedef enum logic {IDLE, TAP} seq_state_t;

    localparam int NUM_TAPS   = 4;
    localparam int B_W        = 9;
    localparam int Z_W        = 19;
    localparam int FIFO_DEPTH = 2;
    localparam int TAG_STAGES = 6;

    function automatic logic [2:0] fb_sel(input logic [1:0] k);
        return {1'b1, k};
    endfunction

endpackage

// File: rtl/dsp19x2_fir_sequencer_if.sv
// Sample-in / result-out stream interface of the FIR sequencer.
//   IN_VALID/IN_READY/IN_B1/IN_B2     : dual-channel sample pair stream
//   OUT_VALID/OUT_READY/OUT_Y1/OUT_Y2 : dual-channel FIR result stream
// Modports: slave = sequencer, master = producer/consumer environment.
interface dsp19x2_fir_sequencer_if;
    import dsp19x2_seq_pkg::*;

    logic           IN_VALID;
    logic           IN_READY;
    logic [B_W-1:0] IN_B1;
    logic [B_W-1:0] IN_B2;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [Z_W-1:0] OUT_Y1;
    logic [Z_W-1:0] OUT_Y2;

    modport slave (
        input  IN_VALID, IN_B1, IN_B2, OUT_READY,
        output IN_READY, OUT_VALID, OUT_Y1, OUT_Y2
    );

    modport master (
        output IN_VALID, IN_B1, IN_B2, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_Y1, OUT_Y2
    );

endinterface

// File: rtl/dsp19x2_fir_sequencer_res_fifo.sv
// dsp19x2_seq_res_fifo: 2-entry result FIFO with occupancy output.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write one entry (never into a full FIFO unless popping too)
//   pop        : consumer takes the head; ignored when empty
//   dout       : head entry, or the last popped entry while empty
//   count      : occupancy 0..2
module dsp19x2_seq_res_fifo
    import dsp19x2_seq_pkg::*;
#(
    parameter int W = 2 * Z_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [FIFO_DEPTH-1:0][W-1:0] mem;
    logic                         wr_ptr;
    logic                         rd_ptr;
    logic [W-1:0]                 last;
    logic                         pop_ok;

    assign pop_ok = pop && (count != 2'd0);
    // Empty FIFO keeps presenting what the consumer saw last.
    assign dout   = (count == 2'd0) ? last : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            last   <= '0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                last   <= mem[rd_ptr];
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop_ok);
        end
    end

    // Credit upstream must make an overflowing push impossible.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop_ok && count == 2'd2));

endmodule

// File: rtl/dsp19x2_fir_sequencer.sv
// dsp19x2_fir_sequencer: drives one DSP19X2 in multiply-accumulate mode
// through 4-tap FIR passes over a dual-channel sample stream.
//   CLK, RESET        : clock, asynchronous active-low reset
//   strm (slave)      : sample-in and result-out valid/ready streams
//   B1, B2            : tap operands from the per-channel delay lines
//   FEEDBACK          : coefficient select {1, tap}; 0 when idle
//   LOAD_ACC          : restarts the accumulator on tap 0
//   SHIFT_RIGHT       : constant SHIFT
//   Z1, Z2            : DSP results, captured DSP_LATENCY cycles after tap 3
//   OVF_CNT           : only with DSP19X2_SEQ_OVF_CNT_EN defined; saturating
//                       count of pushed results at 19'h3FFFF / 19'h40000
module dsp19x2_fir_sequencer
    import dsp19x2_seq_pkg::*;
#(
    parameter int DSP_LATENCY = 2,
    parameter int SHIFT       = 0
) (
    input  logic                      CLK,
    input  logic                      RESET,
    dsp19x2_fir_sequencer_if.slave    strm,
    output logic [B_W-1:0]            B1,
    output logic [B_W-1:0]            B2,
    output logic [2:0]                FEEDBACK,
    output logic                      LOAD_ACC,
    output logic [4:0]                SHIFT_RIGHT,
    input  logic [Z_W-1:0]            Z1,
    input  logic [Z_W-1:0]            Z2
`ifdef DSP19X2_SEQ_OVF_CNT_EN
    ,
    output logic [7:0]                OVF_CNT
`endif
);

    seq_state_t                     state_q, state_d;
    logic [1:0]                     tap_q, tap_d;
    logic                           armed;
    logic [NUM_TAPS-1:0][B_W-1:0]   d1, d2;
    logic [TAG_STAGES-1:0]          tag_pipe;
    logic [1:0]                     inflight;
    logic [1:0]                     fifo_count;
    logic                           last_tap, credit, in_ready, accept;
    logic                           push, pop;

    assign SHIFT_RIGHT = 5'(SHIFT);

    assign last_tap = (state_q == TAP) && (tap_q == 2'd3);
    // Passes in flight plus queued results may never exceed the FIFO depth,
    // so every result has a slot reserved when it is accepted.
    assign credit   = ({1'b0, inflight} + {1'b0, fifo_count}) < 3'(FIFO_DEPTH);
    // armed keeps IN_READY low during and just after reset.
    assign in_ready = armed && ((state_q == IDLE) || last_tap) && credit;
    assign accept   = strm.IN_VALID && in_ready;
    assign push     = tag_pipe[DSP_LATENCY-1];
    assign pop      = strm.OUT_READY && strm.OUT_VALID;

    assign strm.IN_READY  = in_ready;
    assign strm.OUT_VALID = (fifo_count != 2'd0);

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        B1       = '0;
        B2       = '0;
        FEEDBACK = 3'b000;
        LOAD_ACC = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = TAP;
                    tap_d   = 2'd0;
                end
            end
            TAP: begin
                B1       = d1[tap_q];
                B2       = d2[tap_q];
                FEEDBACK = fb_sel(tap_q);
                LOAD_ACC = (tap_q == 2'd0);
                tap_d    = tap_q + 2'd1;
                // Back-to-back pass: tap 3 wraps straight to tap 0.
                if (last_tap && !accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            tap_q    <= 2'd0;
            armed    <= 1'b0;
            d1       <= '0;
            d2       <= '0;
            tag_pipe <= '0;
            inflight <= 2'd0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            armed    <= 1'b1;
            if (accept) begin
                d1 <= {d1[NUM_TAPS-2:0], strm.IN_B1};
                d2 <= {d2[NUM_TAPS-2:0], strm.IN_B2};
            end
            // Tag follows tap 3 down the DSP pipeline to time the Z capture.
            tag_pipe <= {tag_pipe[TAG_STAGES-2:0], last_tap};
            inflight <= inflight + 2'(accept) - 2'(push);
        end
    end

    // Passes are at least 4 cycles apart, so the tag pipe never holds
    // more than two tags.
    assert property (@(posedge CLK) disable iff (!RESET)
        $countones(tag_pipe) <= 2);

    dsp19x2_seq_res_fifo #(.W(2 * Z_W)) u_fifo (
        .clk   (CLK),
        .rst_n (RESET),
        .push  (push),
        .din   ({Z1, Z2}),
        .pop   (pop),
        .dout  ({strm.OUT_Y1, strm.OUT_Y2}),
        .count (fifo_count)
    );

`ifdef DSP19X2_SEQ_OVF_CNT_EN
    logic z_ext;
    assign z_ext = (Z1 == 19'h3FFFF) || (Z1 == 19'h40000) ||
                   (Z2 == 19'h3FFFF) || (Z2 == 19'h40000);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)                                OVF_CNT <= 8'd0;
        else if (push && z_ext && OVF_CNT != 8'hFF) OVF_CNT <= OVF_CNT + 8'd1;
    end
`endif

endmodule

// File: tb/tb_dsp19x2_fir_sequencer.sv
// Self-checking bench for dsp19x2_fir_sequencer with a behavioural DSP19X2
// MAC model (COEFF1_k = k+1, COEFF2_k = 10*(k+1), 2-cycle latency).
module tb_dsp19x2_fir_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [8:0]  B1, B2;
    logic [2:0]  FEEDBACK;
    logic        LOAD_ACC;
    logic [4:0]  SHIFT_RIGHT;
    logic [18:0] Z1, Z2;
`ifdef DSP19X2_SEQ_OVF_CNT_EN
    logic [7:0]  OVF_CNT;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    dsp19x2_fir_sequencer_if sif ();

    dsp19x2_fir_sequencer #(.DSP_LATENCY(2), .SHIFT(0)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .strm        (sif),
        .B1          (B1),
        .B2          (B2),
        .FEEDBACK    (FEEDBACK),
        .LOAD_ACC    (LOAD_ACC),
        .SHIFT_RIGHT (SHIFT_RIGHT),
        .Z1          (Z1),
        .Z2          (Z2)
`ifdef DSP19X2_SEQ_OVF_CNT_EN
        ,
        .OVF_CNT     (OVF_CNT)
`endif
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // DSP19X2 MAC model: input register stage, then accumulator/output reg.
    logic [8:0]         r_b1 = '0, r_b2 = '0;
    logic [2:0]         r_fb = '0;
    logic               r_ld = 1'b0;
    logic signed [18:0] acc1 = '0, acc2 = '0;
    bit                 force_ovf = 1'b0;

    always @(posedge CLK) begin
        r_b1 <= B1;
        r_b2 <= B2;
        r_fb <= FEEDBACK;
        r_ld <= LOAD_ACC;
        acc1 <= 19'((r_ld ? 0 : int'(acc1)) + (int'(r_fb[1:0]) + 1) * int'($signed(r_b1)));
        acc2 <= 19'((r_ld ? 0 : int'(acc2)) + 10 * (int'(r_fb[1:0]) + 1) * int'($signed(r_b2)));
    end
    assign Z1 = force_ovf ? 19'h3FFFF : acc1;
    assign Z2 = acc2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset;
        RESET         = 1'b0;
        sif.IN_VALID  = 1'b0;
        sif.OUT_READY = 1'b0;
        repeat (2) tick();
        RESET = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [8:0]  b1, b2;
        logic [18:0] y1, y2;
    } vec_t;
    localparam int NV = 8;
    vec_t tv[NV];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int acc_cyc[NV];
        int n_acc, got, nvalid, w;
        logic [18:0] pv[2];

        tv[0] = '{9'd1,   9'd2,   19'd1,  19'd20};
        tv[1] = '{9'd0,   9'd0,   19'd2,  19'd40};
        tv[2] = '{9'd0,   9'd0,   19'd3,  19'd60};
        tv[3] = '{9'd0,   9'd0,   19'd4,  19'd80};
        tv[4] = '{9'd5,   9'h1FF, 19'd5,  19'h7FFF6};
        tv[5] = '{9'd3,   9'd1,   19'd13, 19'h7FFF6};
        tv[6] = '{9'h1FE, 9'd4,   19'd19, 19'd30};
        tv[7] = '{9'd7,   9'd0,   19'd32, 19'd70};

        sif.IN_VALID = 1'b0; sif.IN_B1 = '0; sif.IN_B2 = '0; sif.OUT_READY = 1'b0;

        // Reset state
        @(negedge CLK);
        check("rst IN_READY", 32'(sif.IN_READY), 0);
        check("rst OUT_VALID", 32'(sif.OUT_VALID), 0);
        check("rst OUT_Y1", 32'(sif.OUT_Y1), 0);
        check("rst OUT_Y2", 32'(sif.OUT_Y2), 0);
        check("rst B1", 32'(B1), 0);
        check("rst B2", 32'(B2), 0);
        check("rst FEEDBACK", 32'(FEEDBACK), 0);
        check("rst LOAD_ACC", 32'(LOAD_ACC), 0);
        check("rst SHIFT_RIGHT", 32'(SHIFT_RIGHT), 0);
`ifdef DSP19X2_SEQ_OVF_CNT_EN
        check("rst OVF_CNT", 32'(OVF_CNT), 0);
`endif

        // Single pair 1/2: tap sequencing and result latency
        do_reset();
        sif.IN_VALID = 1'b1; sif.IN_B1 = 9'd1; sif.IN_B2 = 9'd2;
        check("single IN_READY", 32'(sif.IN_READY), 1);
        tick();
        sif.IN_VALID = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("single FEEDBACK t%0d", k), 32'(FEEDBACK), 32'(4 + k));
            check($sformatf("single LOAD_ACC t%0d", k), 32'(LOAD_ACC), (k == 0) ? 1 : 0);
            check($sformatf("single B1 t%0d", k), 32'(B1), (k == 0) ? 1 : 0);
            check($sformatf("single B2 t%0d", k), 32'(B2), (k == 0) ? 2 : 0);
            if (k < 3) tick();
        end
        for (int j = 1; j <= 3; j++) begin
            tick();
            check($sformatf("single OUT_VALID t3+%0d", j), 32'(sif.OUT_VALID), (j == 3) ? 1 : 0);
        end
        check("single OUT_Y1", 32'(sif.OUT_Y1), 1);
        check("single OUT_Y2", 32'(sif.OUT_Y2), 20);
        tick();
        check("hold OUT_VALID", 32'(sif.OUT_VALID), 1);
        check("hold OUT_Y1", 32'(sif.OUT_Y1), 1);
        sif.OUT_READY = 1'b1;
        tick();
        sif.OUT_READY = 1'b0;
        check("empty OUT_VALID", 32'(sif.OUT_VALID), 0);
        check("empty keeps OUT_Y2", 32'(sif.OUT_Y2), 20);

        // Table stream: continuous IN_VALID and OUT_READY
        do_reset();
        sif.OUT_READY = 1'b1;
        fork
            begin : producer
                for (int i = 0; i < NV; i++) begin
                    int ww;
                    sif.IN_B1 = tv[i].b1; sif.IN_B2 = tv[i].b2; sif.IN_VALID = 1'b1;
                    ww = 0;
                    while (!sif.IN_READY && ww < 50) begin tick(); ww++; end
                    if (ww >= 50) check($sformatf("stream accept %0d timeout", i), 0, 1);
                    acc_cyc[i] = cyc;
                    tick();
                end
                sif.IN_VALID = 1'b0;
            end
            begin : consumer
                int g, ww;
                g = 0; ww = 0;
                while (g < NV && ww < 400) begin
                    if (sif.OUT_VALID) begin
                        check($sformatf("stream y1[%0d]", g), 32'(sif.OUT_Y1), 32'(tv[g].y1));
                        check($sformatf("stream y2[%0d]", g), 32'(sif.OUT_Y2), 32'(tv[g].y2));
                        g++;
                    end
                    tick(); ww++;
                end
                check("stream result count", 32'(g), NV);
            end
        join
        for (int i = 1; i < NV; i++)
            check($sformatf("stream accept gap %0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 4);
        sif.OUT_READY = 1'b0;

        // Backpressure: OUT_READY low, IN_VALID held high
        do_reset();
        sif.IN_B1 = 9'd1; sif.IN_B2 = 9'd0; sif.IN_VALID = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 40; c++) begin
            if (sif.IN_READY) n_acc++;
            tick();
        end
        check("bp accepts", 32'(n_acc), 2);
        check("bp IN_READY stalled", 32'(sif.IN_READY), 0);
        check("bp OUT_VALID", 32'(sif.OUT_VALID), 1);
        sif.OUT_READY = 1'b1;
        got = 0; n_acc = 0; w = 0;
        while (w < 30) begin
            if (sif.OUT_VALID && got < 2) begin pv[got] = sif.OUT_Y1; got++; end
            if (sif.IN_READY) n_acc++;
            tick(); w++;
        end
        check("bp drained", 32'(got), 2);
        check("bp first", 32'(pv[0]), 1);
        check("bp second", 32'(pv[1]), 3);
        check("bp resume", 32'(n_acc > 0), 1);
        sif.IN_VALID = 1'b0;
        repeat (15) tick();
        sif.OUT_READY = 1'b0;

        // Reset during tap 2
        do_reset();
        sif.OUT_READY = 1'b1;
        sif.IN_B1 = 9'd3; sif.IN_B2 = 9'd4; sif.IN_VALID = 1'b1;
        tick();
        sif.IN_VALID = 1'b0;
        tick(); tick();
        check("midrst at tap2", 32'(FEEDBACK), 6);
        RESET = 1'b0;
        #1;
        check("midrst FEEDBACK", 32'(FEEDBACK), 0);
        check("midrst LOAD_ACC", 32'(LOAD_ACC), 0);
        check("midrst B1", 32'(B1), 0);
        check("midrst IN_READY", 32'(sif.IN_READY), 0);
        check("midrst OUT_VALID", 32'(sif.OUT_VALID), 0);
        tick();
        RESET = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            if (sif.OUT_VALID) nvalid++;
            tick();
        end
        check("midrst no result", 32'(nvalid), 0);
        sif.OUT_READY = 1'b0;

`ifdef DSP19X2_SEQ_OVF_CNT_EN
        // Overflow counter saturation
        do_reset();
        force_ovf = 1'b1;
        sif.OUT_READY = 1'b1; sif.IN_B1 = 9'd1; sif.IN_B2 = 9'd1; sif.IN_VALID = 1'b1;
        got = 0; w = 0;
        while (got < 300 && w < 3000) begin
            if (sif.OUT_VALID) got++;
            tick(); w++;
        end
        sif.IN_VALID = 1'b0;
        repeat (20) tick();
        check("ovf results", 32'(got >= 300), 1);
        check("ovf saturate", 32'(OVF_CNT), 255);
        force_ovf = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
